interrupt_arbiter: RTL
======================

Name: interrupt_arbiter

Overview:
- Collects up to NUM_SRC external interrupt lines, latches rising edges as pending, applies a per-source enable mask and the global interrupt enable, and selects one winner.
- Hands the winner to the interrupt sequencing logic over a req/ack handshake, then holds off further requests until the handler's RTI signals end-of-interrupt.
- Sits between the I/O interrupt pins and the interrupt sequencer in the control unit.

Parameters:
- NUM_SRC, 4, number of interrupt sources (2..8).
- VEC_W, 2, width of the source index; NUM_SRC <= 2**VEC_W is required.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, reset; asynchronous, active-high.
- irq, input, NUM_SRC, raw interrupt lines; rising-edge sensitive.
- gie, input, 1, global interrupt enable (from the flag register).
- mask_we, input, 1, mask write strobe.
- mask_wdata, input, NUM_SRC, new mask value; bit=1 enables that source.
- int_ack, input, 1, sequencer accepts the current request.
- eoi, input, 1, end of interrupt, pulsed by RTI completion.
- int_req, output, 1, request to the sequencer.
- int_vec, output, VEC_W, index of the requesting/serviced source.
- in_service, output, 1, a handler is running.
- pending, output, NUM_SRC, pending-latch contents.
- mask, output, NUM_SRC, current mask register.

Behaviour:
- Reset (async, immediate, from any state):
  - state=IDLE; int_req=0, int_vec=0, in_service=0.
  - pending=0, irq_d=0, mask=all ones.
  - Round-robin pointer=0.
- Edge detect:
  - irq_d registers irq each cycle.
  - pending[i] sets at an edge where irq[i]=1 and irq_d[i]=0.
  - A line held high through reset release therefore registers one edge on the first clock.
  - Masked sources still latch pending; masking only blocks selection.
- Eligible set: pending & mask, considered only when gie=1.
- Mask write: mask<=mask_wdata at the edge where mask_we=1; takes effect for selection from the next cycle.
- FSM states IDLE, REQ, SERVICE:
  - IDLE: if gie and eligible!=0 at an edge, then int_vec<=winner, state<=REQ. int_req=1 is a registered output, asserted from that edge.
  - REQ:
    - int_req=1; int_vec is frozen.
    - A later higher-priority edge, a mask change or gie dropping does not withdraw or alter the request.
    - On int_ack: pending[int_vec] clears, state<=SERVICE, int_req<=0, in_service<=1.
  - SERVICE:
    - in_service=1; int_vec holds the serviced index.
    - New edges keep latching.
    - On eoi: state<=IDLE, in_service<=0.
    - A new request can issue no earlier than the edge after returning to IDLE (one idle cycle minimum).
- Ignored inputs: int_ack outside REQ; eoi outside SERVICE.
- Latency: irq sampled high at edge E0 sets pending; int_req is high after E1.
- Simultaneous set and clear on the same bit at ack: the set wins, so pending stays 1 and the new occurrence is not lost.
- Fixed priority (default): lowest index wins.

Optional Feature:
- Macro ROUND_ROBIN_EN.
- Defined:
  - Winner search starts at index (last_acked+1) mod NUM_SRC and wraps.
  - The pointer updates only on int_ack.
  - Reset pointer=0, so index 0 is searched first.
- Undefined: fixed priority, index 0 highest; no pointer register.

Test Plan:
- Reset: assert rst mid-cycle with pending=4'b0110 and state SERVICE -> outputs immediately int_req=0, in_service=0, int_vec=0, pending=0, mask=4'b1111.
- Single source: gie=1, irq[2] pulsed high one cycle -> pending=4'b0100 after E0, int_req=1 and int_vec=2 after E1. Ack -> pending=0, in_service=1, int_req=0. eoi -> in_service=0, no further request.
- Priority: irq[1] and irq[3] rise together -> int_vec=1 first. After ack and eoi -> int_vec=3 requested. With ROUND_ROBIN_EN after servicing 3, simultaneous irq[0] and irq[3] -> int_vec=0.
- Mask: write mask=4'b1110, pulse irq[0] -> pending=4'b0001, int_req stays 0 for 10 cycles. Write mask=4'b1111 -> int_req=1, int_vec=0 two edges later.
- Gating: gie=0 with pending[1]=1 -> no request. gie=1 -> request vec 1. Dropping gie during REQ keeps int_req=1 until ack.
- Collision: irq[2] new rising edge at the same edge as int_ack for vec 2 -> pending[2] remains 1. After eoi, vec 2 is requested again.

Source files
------------

// File: rtl/interrupt_arbiter.sv
// rtl/interrupt_arbiter.sv - rising-edge interrupt collector with req/ack/eoi hand-off
//
// Purpose:
//   Latches rising edges on the raw interrupt lines as pending bits. It gates the
//   pending bits with the per-source mask and the global interrupt enable, then
//   picks one winner. The winner is offered to the interrupt sequencer over a
//   req/ack handshake. While a handler runs, no new request is raised until the
//   handler's RTI pulses end-of-interrupt.
//
// Ports:
//   clk        in   1        clock, rising edge
//   rst        in   1        asynchronous active-high reset
//   irq        in   NUM_SRC  raw interrupt lines (rising-edge sensitive)
//   gie        in   1        global interrupt enable
//   mask_we    in   1        mask write strobe
//   mask_wdata in   NUM_SRC  new mask value (1 = source enabled)
//   int_ack    in   1        sequencer accepts the current request
//   eoi        in   1        end of interrupt (RTI completion)
//   int_req    out  1        request to the sequencer (registered)
//   int_vec    out  VEC_W    index of the requesting / serviced source
//   in_service out  1        a handler is running
//   pending    out  NUM_SRC  pending-latch contents
//   mask       out  NUM_SRC  current mask register
//
// Configuration:
//   ROUND_ROBIN_EN  When defined, the winner search starts one past the last
//                   acknowledged source and wraps around. When undefined, fixed
//                   priority applies and the lowest index wins.
//
// Parameter constraints: NUM_SRC in 2..8, NUM_SRC <= 2**VEC_W.

module interrupt_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int VEC_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq,
  input  logic               gie,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  input  logic               int_ack,
  input  logic               eoi,
  output logic               int_req,
  output logic [VEC_W-1:0]   int_vec,
  output logic               in_service,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] mask
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] SERVICE = 2'd2;

  logic [1:0]         state_q,      state_d;
  logic [NUM_SRC-1:0] irq_d_q;
  logic [NUM_SRC-1:0] pending_q,    pending_d;
  logic [NUM_SRC-1:0] mask_q,       mask_d;
  logic               int_req_q,    int_req_d;
  logic [VEC_W-1:0]   int_vec_q,    int_vec_d;
  logic               in_service_q, in_service_d;

  logic [NUM_SRC-1:0] irq_rise;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] vec_onehot;
  logic               ack_fire;
  logic [VEC_W-1:0]   winner;

  // A line held high through reset release shows up as one edge on the first
  // clock, because irq_d_q comes out of reset as zero.
  assign irq_rise = irq & ~irq_d_q;

  // Masked sources keep latching pending. The mask and gie only decide whether
  // a source can be selected.
  assign eligible = gie ? (pending_q & mask_q) : '0;

  assign ack_fire = (state_q == REQ) && int_ack;

  always_comb begin
    vec_onehot = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      vec_onehot[i] = (int_vec_q == VEC_W'(i));
    end
  end

`ifdef ROUND_ROBIN_EN
  logic [VEC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [VEC_W-1:0] win_hi, win_any;
  logic             hi_hit;

  // Wrap-around search done as two passes. The first pass takes the lowest
  // eligible index at or above the pointer. If nothing qualifies there, the
  // second pass wraps to the lowest eligible index overall. Scanning downward
  // means the last hit is the lowest index.
  always_comb begin
    win_hi  = '0;
    win_any = '0;
    hi_hit  = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_any = VEC_W'(i);
        if (VEC_W'(i) >= rr_ptr_q) begin
          win_hi = VEC_W'(i);
          hi_hit = 1'b1;
        end
      end
    end
    winner = hi_hit ? win_hi : win_any;
  end

  // The pointer moves only when a request is accepted. It then points one
  // past the source that was just acknowledged.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (ack_fire) begin
      if (int_vec_q == VEC_W'(NUM_SRC - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = int_vec_q + VEC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  // Fixed priority: scan downward so the lowest eligible index is written last.
  always_comb begin
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner = VEC_W'(i);
      end
    end
  end
`endif

  // Pending update. At ack, the serviced bit is cleared before the new edges
  // are OR-ed in. A fresh edge on the serviced line in the same cycle therefore
  // survives.
  always_comb begin
    pending_d = pending_q & ~(ack_fire ? vec_onehot : '0);
    pending_d = pending_d | irq_rise;
  end

  always_comb begin
    mask_d = mask_we ? mask_wdata : mask_q;
  end

  always_comb begin
    state_d      = state_q;
    int_req_d    = int_req_q;
    int_vec_d    = int_vec_q;
    in_service_d = in_service_q;
    case (state_q)
      IDLE: begin
        if (eligible != '0) begin
          int_vec_d = winner;
          int_req_d = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        // Once raised, the request is frozen. Later edges, mask writes and
        // gie changes are ignored until the sequencer acknowledges it.
        if (int_ack) begin
          int_req_d    = 1'b0;
          in_service_d = 1'b1;
          state_d      = SERVICE;
        end
      end
      SERVICE: begin
        // Returning to IDLE here guarantees at least one idle edge before the
        // next request can be raised.
        if (eoi) begin
          in_service_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d      = IDLE;
        int_req_d    = 1'b0;
        in_service_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      irq_d_q      <= '0;
      pending_q    <= '0;
      mask_q       <= '1;
      int_req_q    <= 1'b0;
      int_vec_q    <= '0;
      in_service_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      irq_d_q      <= irq;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      int_req_q    <= int_req_d;
      int_vec_q    <= int_vec_d;
      in_service_q <= in_service_d;
    end
  end

  assign int_req    = int_req_q;
  assign int_vec    = int_vec_q;
  assign in_service = in_service_q;
  assign pending    = pending_q;
  assign mask       = mask_q;

endmodule
